// File: rtl/systolic_array_sched_ws_seq.sv
// Tile scheduler for the weight-stationary systolic array.
// Each tile runs in four phases: load NUM_ROW weight rows, stream the
// requested number of activation vectors, wait for the array to drain,
// then pulse done. Every accepted beat reaches the sa_* outputs one
// cycle later.
module systolic_array_sched_ws_seq #(
    parameter int NUM_ROW    = 8,
    parameter int NUM_COL    = 8,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [CNT_WIDTH-1:0]          cfg_num_vec,
    input  logic [NUM_ROW*DATA_WIDTH-1:0] w_data,
    input  logic                          w_valid,
    output logic                          w_ready,
    input  logic [NUM_ROW*DATA_WIDTH-1:0] a_data,
    input  logic                          a_valid,
    output logic                          a_ready,
    output logic [NUM_ROW*DATA_WIDTH-1:0] sa_data,
    output logic [NUM_ROW-1:0]            sa_valid,
    output logic                          sa_last,
    output logic                          sa_cmd,
    output logic                          busy,
    output logic                          done
);

    localparam int DRAIN_CYCLES = NUM_ROW + NUM_COL;
    localparam int VEC_W        = NUM_ROW * DATA_WIDTH;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] W_LAST_IDX = CNT_WIDTH'(NUM_ROW - 1);
    localparam logic [CNT_WIDTH-1:0] D_LAST_IDX = CNT_WIDTH'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   num_q, num_d;
    logic [CNT_WIDTH-1:0]   wcnt_q, wcnt_d;
    logic [CNT_WIDTH-1:0]   acnt_q, acnt_d;
    logic [CNT_WIDTH-1:0]   dcnt_q, dcnt_d;
    logic [VEC_W-1:0]       sa_data_q, sa_data_d;
    logic [NUM_ROW-1:0]     sa_valid_q, sa_valid_d;
    logic                   sa_last_q, sa_last_d;
    logic                   sa_cmd_q, sa_cmd_d;

    // Readies, busy and done depend on the state alone, never on the valids.
    assign w_ready  = (state_q == LOAD_W);
    assign a_ready  = (state_q == STREAM);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

    assign sa_data  = sa_data_q;
    assign sa_valid = sa_valid_q;
    assign sa_last  = sa_last_q;
    assign sa_cmd   = sa_cmd_q;

    // Next-state logic: phase sequencing, beat counting and output staging.
    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        wcnt_d     = wcnt_q;
        acnt_d     = acnt_q;
        dcnt_d     = dcnt_q;
        sa_data_d  = sa_data_q;
        sa_cmd_d   = sa_cmd_q;
        sa_valid_d = '0;
        sa_last_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && (cfg_num_vec != '0)) begin
                    num_d   = cfg_num_vec;
                    wcnt_d  = '0;
                    acnt_d  = '0;
                    dcnt_d  = '0;
                    state_d = LOAD_W;
                end
            end
            LOAD_W: begin
                if (w_valid) begin
                    sa_data_d  = w_data;
                    sa_valid_d = '1;
                    sa_cmd_d   = 1'b1;
                    wcnt_d     = wcnt_q + CNT_ONE;
                    if (wcnt_q == W_LAST_IDX) begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (a_valid) begin
                    sa_data_d  = a_data;
                    sa_valid_d = '1;
                    sa_cmd_d   = 1'b0;
                    acnt_d     = acnt_q + CNT_ONE;
                    // Comparing against num_q-1 keeps the full counter range usable.
                    if (acnt_q == (num_q - CNT_ONE)) begin
                        sa_last_d = 1'b1;
                        state_d   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                dcnt_d = dcnt_q + CNT_ONE;
                if (dcnt_q == D_LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered array outputs; reset discards any tile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            num_q      <= '0;
            wcnt_q     <= '0;
            acnt_q     <= '0;
            dcnt_q     <= '0;
            sa_data_q  <= '0;
            sa_valid_q <= '0;
            sa_last_q  <= 1'b0;
            sa_cmd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            wcnt_q     <= wcnt_d;
            acnt_q     <= acnt_d;
            dcnt_q     <= dcnt_d;
            sa_data_q  <= sa_data_d;
            sa_valid_q <= sa_valid_d;
            sa_last_q  <= sa_last_d;
            sa_cmd_q   <= sa_cmd_d;
        end
    end

endmodule

// File: tb/tb_systolic_array_sched_ws_seq.sv
// Testbench for systolic_array_sched_ws_seq with a 4x4 array.
// A tile's full expected beat stream is queued when the tile is issued,
// and a negedge monitor pops it whenever sa_valid is seen.
module tb_systolic_array_sched_ws_seq;

    localparam int NR    = 4;
    localparam int NC    = 4;
    localparam int DW    = 8;
    localparam int CW    = 16;
    localparam int VW    = NR * DW;
    localparam int DRAIN = NR + NC;

    typedef struct {
        logic [VW-1:0] data;
        logic          cmd;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] cfg_num_vec = '0;
    logic [VW-1:0] w_data = '0;
    logic          w_valid = 1'b0;
    logic          w_ready;
    logic [VW-1:0] a_data = '0;
    logic          a_valid = 1'b0;
    logic          a_ready;
    logic [VW-1:0] sa_data;
    logic [NR-1:0] sa_valid;
    logic          sa_last;
    logic          sa_cmd;
    logic          busy;
    logic          done;

    int    asserts = 0;
    int    fails   = 0;
    beat_t sbQ[$];

    systolic_array_sched_ws_seq #(
        .NUM_ROW    (NR),
        .NUM_COL    (NC),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_num_vec (cfg_num_vec),
        .w_data      (w_data),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .a_data      (a_data),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .sa_data     (sa_data),
        .sa_valid    (sa_valid),
        .sa_last     (sa_last),
        .sa_cmd      (sa_cmd),
        .busy        (busy),
        .done        (done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected beat per observed sa_valid, checks holds otherwise.
    initial begin
        beat_t         e;
        logic [VW-1:0] lastData;
        logic          lastCmd;
        lastData = '0;
        lastCmd  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                lastData = '0;
                lastCmd  = 1'b0;
            end else if (sa_valid != '0) begin
                checkOutput("sa_valid_all_ones", 64'(sa_valid), 64'({NR{1'b1}}));
                if (sbQ.size() == 0) begin
                    asserts++;
                    fails++;
                    $display("[TB] FAIL unexpected_beat: got data %0h cmd %0b, expected no beat at %0t",
                             sa_data, sa_cmd, $time);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("beat_data", 64'(sa_data), 64'(e.data));
                    checkOutput("beat_cmd", 64'(sa_cmd), 64'(e.cmd));
                    checkOutput("beat_last", 64'(sa_last), 64'(e.last));
                end
                lastData = sa_data;
                lastCmd  = sa_cmd;
            end else begin
                checkOutput("idle_sa_last", 64'(sa_last), 64'(0));
                checkOutput("hold_sa_data", 64'(sa_data), 64'(lastData));
                checkOutput("hold_sa_cmd", 64'(sa_cmd), 64'(lastCmd));
            end
        end
    end

    // Runs one tile from the current negedge; mode 0 = no bubbles,
    // 1 = bubble on the 2nd ready cycle of each phase, 2 = random bubbles.
    // abortAfter >= 0 asserts reset once that many activations were accepted.
    task automatic applyStimulus(input int num, input int mode, input bit hold,
                                 input bit disturb, input int abortAfter);
        logic [VW-1:0] wts[NR];
        logic [VW-1:0] acts[$];
        beat_t         b;
        int            wi = 0;
        int            ai = 0;
        int            wCyc = 0;
        int            aCyc = 0;
        int            bubbles = 0;
        int            cycles = 0;
        int            nActs;
        bit            bub;

        for (int i = 0; i < NR; i++) begin
            wts[i] = $urandom;
            b.data = wts[i];
            b.cmd  = 1'b1;
            b.last = 1'b0;
            sbQ.push_back(b);
        end
        for (int i = 0; i < num; i++) acts.push_back($urandom);
        nActs = (abortAfter >= 0) ? abortAfter : num;
        for (int i = 0; i < nActs; i++) begin
            b.data = acts[i];
            b.cmd  = 1'b0;
            b.last = (i == num - 1);
            sbQ.push_back(b);
        end

        cfg_num_vec = CW'(num);
        forever begin
            if (cycles > 0 && done) begin
                checkOutput("done_latency", 64'(cycles), 64'(1 + NR + num + DRAIN + bubbles));
                break;
            end
            if (cycles > 200) begin
                asserts++;
                fails++;
                $display("[TB] FAIL tile_timeout: got no done after %0d cycles, expected %0d",
                         cycles, 1 + NR + num + DRAIN + bubbles);
                start = 1'b0;
                return;
            end
            if (abortAfter >= 0 && ai == abortAfter && a_ready) begin
                start   = 1'b0;
                w_valid = 1'b0;
                a_valid = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                checkOutput("rst_sa_valid", 64'(sa_valid), 64'(0));
                checkOutput("rst_sa_data", 64'(sa_data), 64'(0));
                checkOutput("rst_sa_last", 64'(sa_last), 64'(0));
                checkOutput("rst_sa_cmd", 64'(sa_cmd), 64'(0));
                checkOutput("rst_busy", 64'(busy), 64'(0));
                checkOutput("rst_a_ready", 64'(a_ready), 64'(0));
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checkOutput("rst_done", 64'(done), 64'(0));
                end
                rst_n = 1'b1;
                return;
            end

            start = (cycles == 0) || hold;
            if (disturb && cycles > 0) cfg_num_vec = CW'($urandom);
            if (disturb && a_ready && aCyc == 0) begin
                start       = 1'b1;
                cfg_num_vec = CW'(9);
            end

            w_data  = $urandom;
            w_valid = 1'($urandom);
            if (w_ready && wi < NR) begin
                bub = (mode == 1) ? (wCyc == 1) : (mode == 2) ? ($urandom_range(99) < 30) : 1'b0;
                wCyc++;
                if (bub) begin
                    w_valid = 1'b0;
                    bubbles++;
                end else begin
                    w_valid = 1'b1;
                    w_data  = wts[wi];
                    wi++;
                end
            end

            a_data  = $urandom;
            a_valid = 1'($urandom);
            if (a_ready && ai < num) begin
                bub = (mode == 1) ? (aCyc == 1) : (mode == 2) ? ($urandom_range(99) < 30) : 1'b0;
                aCyc++;
                if (bub) begin
                    a_valid = 1'b0;
                    bubbles++;
                end else begin
                    a_valid = 1'b1;
                    a_data  = acts[ai];
                    ai++;
                end
            end

            @(posedge clk);
            cycles++;
            @(negedge clk);
        end

        w_valid = 1'b0;
        a_valid = 1'b0;
        checkOutput("weights_sent", 64'(wi), 64'(NR));
        checkOutput("acts_sent", 64'(ai), 64'(num));
        @(posedge clk);
        @(negedge clk);
        checkOutput("busy_after_done", 64'(busy), 64'(0));
        checkOutput("done_one_cycle", 64'(done), 64'(0));
        if (!hold) start = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence of directed and randomized tiles.
    initial begin
        #12;
        checkOutput("reset_sa_valid", 64'(sa_valid), 64'(0));
        checkOutput("reset_sa_data", 64'(sa_data), 64'(0));
        checkOutput("reset_sa_last", 64'(sa_last), 64'(0));
        checkOutput("reset_sa_cmd", 64'(sa_cmd), 64'(0));
        checkOutput("reset_w_ready", 64'(w_ready), 64'(0));
        checkOutput("reset_a_ready", 64'(a_ready), 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_reset_busy", 64'(busy), 64'(0));
        checkOutput("post_reset_w_ready", 64'(w_ready), 64'(0));

        $display("[TB] clean tile, 3 vectors");
        applyStimulus(3, 0, 1'b0, 1'b0, -1);

        $display("[TB] tile with one bubble per phase");
        applyStimulus(3, 1, 1'b0, 1'b0, -1);

        $display("[TB] start with zero vectors is ignored");
        start       = 1'b1;
        cfg_num_vec = '0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            checkOutput("zero_cfg_busy", 64'(busy), 64'(0));
            checkOutput("zero_cfg_done", 64'(done), 64'(0));
        end

        $display("[TB] start and cfg changes mid-tile are ignored");
        applyStimulus(3, 0, 1'b0, 1'b1, -1);

        $display("[TB] reset during stream, then a fresh tile");
        applyStimulus(3, 0, 1'b0, 1'b0, 1);
        applyStimulus(1, 0, 1'b0, 1'b0, -1);

        $display("[TB] back-to-back tiles with start held");
        applyStimulus(1, 0, 1'b1, 1'b0, -1);
        applyStimulus(2, 0, 1'b0, 1'b0, -1);

        $display("[TB] randomized tiles");
        for (int t = 0; t < 8; t++) begin
            applyStimulus($urandom_range(6, 1), 2, 1'b0, 1'b0, -1);
        end

        for (int k = 0; k < 5; k++) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(sbQ.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
